// File: rtl/scoreboard_pkg.sv
// Shared register-file definitions and scoreboard types.
// rvga_defines fixes the architectural register count; rvga_types derives the index type from it.
package rvga_defines;
  localparam int unsigned RVGA_NUM_REGS = 32;
  localparam int unsigned RVGA_REG_W    = $clog2(RVGA_NUM_REGS);
endpackage

package rvga_types;
  import rvga_defines::*;

  typedef logic [RVGA_REG_W-1:0] rvga_reg;

  typedef enum logic {
    LONG_IDLE,
    LONG_BUSY
  } long_state_e;
endpackage

// File: rtl/scoreboard_long_unit_ctrl.sv
// Occupancy tracker for the single shared long-latency (mul/div) unit.
module long_unit_ctrl
  import rvga_types::*;
(
  input  logic clk,
  input  logic reset,
  input  logic long_fire,
  input  logic long_done,
  output logic long_busy
);

  long_state_e state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= LONG_IDLE;
    else       state <= state_next;
  end

  // A completion pulse while idle is ignored; a fire in the done cycle keeps the unit busy.
  always_comb begin
    state_next = state;
    unique case (state)
      LONG_IDLE: if (long_fire) state_next = LONG_BUSY;
      LONG_BUSY: if (long_done && !long_fire) state_next = LONG_IDLE;
      default:   state_next = LONG_IDLE;
    endcase
  end

  assign long_busy = (state == LONG_BUSY);

endmodule

// File: rtl/scoreboard.sv
// In-order issue scoreboard: RAW/WAW tracking per register, long-unit serialisation,
// and a saturating stall-cycle counter.
module scoreboard
  import rvga_defines::*;
  import rvga_types::*;
#(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_v,
  input  rvga_reg                issue_rs1,
  input  rvga_reg                issue_rs2,
  input  logic                   issue_rs1_v,
  input  logic                   issue_rs2_v,
  input  rvga_reg                issue_rd,
  input  logic                   issue_rd_w_v,
  input  logic                   issue_long_v,
  input  logic                   flush,
  input  logic                   release_v,
  input  rvga_reg                release_rd,
  input  logic                   long_done,
  output logic                   stall,
  output logic                   issue_fire,
  output logic                   long_busy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [RVGA_NUM_REGS-1:0] REG_ONE = RVGA_NUM_REGS'(1);
  localparam logic [STALL_CNT_W-1:0]   CNT_ONE = STALL_CNT_W'(1);
  localparam logic [STALL_CNT_W-1:0]   CNT_MAX = '1;

  logic [RVGA_NUM_REGS-1:0] pending, pending_next;
  logic [RVGA_NUM_REGS-1:0] release_mask, ready;
  logic                     rs1_haz, rs2_haz, waw_haz, long_haz;

  // Writeback bypass: a register released this cycle already counts as ready.
  assign release_mask = release_v ? (REG_ONE << release_rd) : '0;
  assign ready        = ~pending | release_mask;

  assign rs1_haz  = issue_rs1_v  && (issue_rs1 != '0) && !ready[issue_rs1];
  assign rs2_haz  = issue_rs2_v  && (issue_rs2 != '0) && !ready[issue_rs2];
  assign waw_haz  = issue_rd_w_v && (issue_rd  != '0) && !ready[issue_rd];
  assign long_haz = issue_long_v && long_busy && !long_done;

  assign stall      = issue_v && (rs1_haz || rs2_haz || waw_haz || long_haz);
  assign issue_fire = issue_v && !stall && !flush;

  // Clear-then-set ordering lets a new write win over a release of the same register.
  always_comb begin
    pending_next = pending & ~release_mask;
    if (issue_fire && issue_rd_w_v && (issue_rd != '0))
      pending_next[issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= '0;
      stall_count <= '0;
    end else begin
      pending <= pending_next;
      if (issue_v && stall && !flush && (stall_count != CNT_MAX))
        stall_count <= stall_count + CNT_ONE;
    end
  end

  long_unit_ctrl u_long_unit_ctrl (
    .clk       (clk),
    .reset     (reset),
    .long_fire (issue_fire && issue_long_v),
    .long_done (long_done),
    .long_busy (long_busy)
  );

endmodule

// File: doc/scoreboard.md
# scoreboard

In-order issue controller between register fetch and execute. Tracks which architectural registers have a write in flight and stalls register fetch on read-after-write and write-after-write hazards. Also serialises the single shared long-latency unit (mul/div) and counts stall cycles for performance monitoring. Complements the single-cycle execute→rfetch forwarding path by covering every producer that forwarding cannot satisfy.

## Interface
Parameters:
- STALL_CNT_W, 32, width of the saturating stall-cycle counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- issue_v  in  1  rfetch holds a valid instruction
- issue_rs1 / issue_rs2  in  rvga_reg  source register indices
- issue_rs1_v / issue_rs2_v  in  1  instruction actually reads rs1 / rs2
- issue_rd  in  rvga_reg  destination index
- issue_rd_w_v  in  1  instruction writes rd
- issue_long_v  in  1  instruction goes to the long-latency unit
- flush  in  1  kill the instruction in rfetch this cycle
- release_v  in  1  writeback releases a pending destination
- release_rd  in  rvga_reg  register being released
- long_done  in  1  one-cycle pulse: long unit has finished its operation
- stall  out  1  hold rfetch this cycle
- issue_fire  out  1  issue_v & ~stall & ~flush
- long_busy  out  1  long unit occupied
- stall_count  out  STALL_CNT_W  saturating count of stalled cycles

## Operation
- State: pending[31:1], one bit per register; x0 is never pending and never causes a stall.
- Long-unit FSM: IDLE, BUSY.
  - IDLE→BUSY on issue_fire & issue_long_v.
  - BUSY→IDLE on long_done, unless a new long op fires in the same cycle, in which case it stays BUSY.
- A register is ready if it is not pending, or if release_v & release_rd equals it in the same cycle (writeback bypass).
- stall = issue_v & (rs1 hazard | rs2 hazard | waw hazard | long hazard), where:
  - rs hazard: rs_v & rs≠0 & rs not ready
  - waw hazard: issue_rd_w_v & rd≠0 & rd not ready
  - long hazard: issue_long_v & long_busy & ~long_done
- stall is a function of current state and inputs only; it is independent of flush.
- Pending updates, registered:
  - Release clears pending[release_rd].
  - issue_fire & issue_rd_w_v & rd≠0 sets pending[issue_rd].
  - Set wins when both hit the same register.
- Release of a non-pending register, or of x0, is ignored.
- Pipeline contract: every instruction that set a pending bit produces exactly one release, even if it is later squashed. The scoreboard therefore clears nothing on flush.
- flush suppresses issue_fire and all state updates caused by the rfetch instruction. Releases and long_done are still honoured.
- stall_count increments when issue_v & stall & ~flush, and saturates at all-ones.

## Timing
- Reset values: pending all 0, FSM IDLE, long_busy 0, stall_count 0.
- Combinational outputs: stall and issue_fire, which are 0 whenever issue_v=0.
- Zero-cycle hazard resolution: a release in cycle N unblocks a dependent issue in cycle N.
- Set latency: an issue_fire in cycle N makes the register pending from cycle N+1. A back-to-back dependent instruction in N+1 stalls unless release arrives in N+1.
- long_busy is registered: it rises the cycle after a long issue and falls the cycle after long_done.
- long_done while IDLE is ignored.
- Reset asserted mid-operation returns all state to reset values on the next edge, overriding simultaneous issue and release.

## Structure
- The rvga_types package holds rvga_reg and a new enum long_state_e {LONG_IDLE, LONG_BUSY}.
- The register count (32) comes from existing rvga_defines.
- One sub-module, long_unit_ctrl, contains the FSM and long_busy.
- The scoreboard top contains the pending vector, the hazard logic and the counter.

## Test plan
- Reset, then issue_v with rs1=5, rs2=6, rd=7, rd_w_v=1 → stall=0, issue_fire=1; pending[7]=1 next cycle.
- Next cycle, issue rs1=7 with no release → stall=1, stall_count 0→1. Then release_rd=7 in the same cycle as retried issue → stall=0, fire=1.
- Issue rd=0 repeatedly → never pending; a following rs1=0 read never stalls.
- Long op fires → long_busy=1. Second long op stalls until the long_done cycle, fires in that cycle, and long_busy stays 1.
- Issue with rd=9 plus flush=1 → issue_fire=0, pending[9] stays 0, stall_count unchanged.
- Release rd=3 while issuing a write to rd=3 with pending[3]=1 → fire=1, pending[3]=1 afterwards. Then assert reset with release_v=1 → all pending cleared, stall_count=0.
